regfile_wb: RTL and testbench

Write-back register file for the 32-entry, 32-bit integer register set. Accepts write requests from the write-back stage over a valid/ready handshake and decodes the 5-bit destination index to a one-hot write-enable vector. Updates the addressed register and serves two combinational read ports to the decode stage. Also provides a sequenced bulk-clear operation used by the debug/boot controller.

---
 rtl/regfile_wb_pkg.sv | 15 +
 rtl/regfile_wb_onehot_dec.sv | 19 +
 rtl/regfile_wb.sv | 139 +++++++++++++
 tb/tb_regfile_wb.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_pkg.sv
// Shared definitions for the write-back register file: index width,
// register count, the index type and the FSM state encoding.
package regfile_wb_pkg;

    localparam int REG_IDX_W = 5;
    localparam int NREGS     = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef enum logic {
        RF_IDLE,
        RF_CLEAR
    } rf_state_t;

endpackage

// File: rtl/regfile_wb_onehot_dec.sv
// rf_wr_onehot_dec: 5-bit register index to 32-bit one-hot write enable.
// The output is all zeros whenever the enable is low.
module rf_wr_onehot_dec
    import regfile_wb_pkg::*;
(
    input  logic                 en,
    input  logic [REG_IDX_W-1:0] idx,
    output logic [NREGS-1:0]     onehot
);

    // One comparator per register; at most one bit can match a given index.
    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_dec
            assign onehot[gi] = en && (idx == REG_IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/regfile_wb.sv
// regfile_wb: 32 x DATA_W write-back register file with two combinational
// read ports and a sequenced bulk clear (indices 1..31, one per cycle).
// Register 0 is hardwired to zero.
// Optional feature macro: REGFILE_BYPASS_EN enables same-cycle forwarding
// of a firing write to a read port addressing the same non-zero index.
module regfile_wb
    import regfile_wb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [4:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr_start,
    output logic              clr_busy,
    input  logic [4:0]        rd_addr_a,
    input  logic [4:0]        rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b
);

    rf_state_t          state_reg, state_next;
    reg_idx_t           clr_cnt_reg, clr_cnt_next;
    logic [DATA_W-1:0]  regs_reg [NREGS];

    logic               clr_active;
    logic               wr_fire;
    logic [NREGS-1:0]   wr_onehot;
    logic [NREGS-1:0]   clr_onehot;
    logic [NREGS-1:0]   we;
    logic [DATA_W-1:0]  wdata;
    logic [DATA_W-1:0]  stored_a;
    logic [DATA_W-1:0]  stored_b;

    assign clr_active = (state_reg == RF_CLEAR);
    assign wr_fire    = wr_valid && wr_ready;

    rf_wr_onehot_dec u_wr_dec (
        .en     (wr_fire),
        .idx    (wr_addr),
        .onehot (wr_onehot)
    );

    rf_wr_onehot_dec u_clr_dec (
        .en     (clr_active),
        .idx    (clr_cnt_reg),
        .onehot (clr_onehot)
    );

    // The clear sequence owns the write path while it runs; no writes fire then.
    assign we    = clr_active ? clr_onehot : wr_onehot;
    assign wdata = clr_active ? '0 : wr_data;

    // Next-state, clear counter and handshake outputs.
    always_comb begin
        state_next   = state_reg;
        clr_cnt_next = clr_cnt_reg;
        wr_ready     = 1'b0;
        clr_busy     = 1'b0;
        case (state_reg)
            RF_IDLE: begin
                wr_ready = 1'b1;
                if (clr_start) begin
                    state_next   = RF_CLEAR;
                    clr_cnt_next = reg_idx_t'(1);
                end
            end
            RF_CLEAR: begin
                clr_busy = 1'b1;
                if (clr_cnt_reg == reg_idx_t'(NREGS - 1)) begin
                    state_next   = RF_IDLE;
                    clr_cnt_next = '0;
                end else begin
                    clr_cnt_next = clr_cnt_reg + reg_idx_t'(1);
                end
            end
            default: begin
                state_next   = RF_IDLE;
                clr_cnt_next = '0;
            end
        endcase
    end

    // FSM state and clear counter registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg   <= RF_IDLE;
            clr_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_cnt_reg <= clr_cnt_next;
        end
    end

    // Register storage; entry 0 is never written so it stays zero.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (we[i] && (i != 0)) begin
                    regs_reg[i] <= wdata;
                end
            end
        end
    end

    // Combinational read of stored state, index 0 forced to zero.
    always_comb begin
        stored_a = (rd_addr_a == 5'd0) ? '0 : regs_reg[rd_addr_a];
        stored_b = (rd_addr_b == 5'd0) ? '0 : regs_reg[rd_addr_b];
    end

`ifdef REGFILE_BYPASS_EN
    // Write-through forwarding of a firing write to a matching non-zero index.
    always_comb begin
        rd_data_a = stored_a;
        rd_data_b = stored_b;
        if (wr_fire && (wr_addr != 5'd0) && (wr_addr == rd_addr_a)) begin
            rd_data_a = wr_data;
        end
        if (wr_fire && (wr_addr != 5'd0) && (wr_addr == rd_addr_b)) begin
            rd_data_b = wr_data;
        end
    end
`else
    // No forwarding: a same-cycle read of the written index returns the old value.
    always_comb begin
        rd_data_a = stored_a;
        rd_data_b = stored_b;
    end
`endif

endmodule

// File: tb/tb_regfile_wb.sv
// Self-checking bench for regfile_wb: directed scenarios plus random
// traffic, compared cycle by cycle against a behavioural register model.
module tb_regfile_wb;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        clr_start;
    logic        clr_busy;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;
    logic [31:0] rd_data_a;
    logic [31:0] rd_data_b;

    int errors = 0;
    int checks = 0;

    // Behavioural model: register contents plus "clear in progress" and
    // the next index the clear sequence will zero.
    logic [31:0] m_regs [32];
    bit          m_clearing = 1'b0;
    int          m_clr_idx  = 0;

    regfile_wb #(.DATA_W(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [4:0] ra, input logic v,
                                             input logic [4:0] a, input logic [31:0] d);
        logic [31:0] val;
        val = (ra == 5'd0) ? 32'h0 : m_regs[ra];
`ifdef REGFILE_BYPASS_EN
        if (!m_clearing && v && a != 5'd0 && a == ra) val = d;
`endif
        return val;
    endfunction

    // One clock cycle: drive inputs, check outputs mid-cycle, advance model at the edge.
    task automatic tick(input logic v, input logic [4:0] a, input logic [31:0] d,
                        input logic cs, input logic [4:0] ra, input logic [4:0] rb);
        wr_valid = v; wr_addr = a; wr_data = d; clr_start = cs;
        rd_addr_a = ra; rd_addr_b = rb;
        #4;
        check("wr_ready", {31'b0, wr_ready}, {31'b0, !m_clearing});
        check("clr_busy", {31'b0, clr_busy}, {31'b0, m_clearing});
        check($sformatf("rd_a[%0d]", ra), rd_data_a, model_rd(ra, v, a, d));
        check($sformatf("rd_b[%0d]", rb), rd_data_b, model_rd(rb, v, a, d));
        @(posedge clk);
        #1;
        if (!reset_n) begin
            $display("reset cycle");
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
            m_clearing = 1'b0;
        end else if (m_clearing) begin
            m_regs[m_clr_idx] = 32'h0;
            if (m_clr_idx == 31) m_clearing = 1'b0;
            else m_clr_idx++;
        end else begin
            if (v) begin
                $display("write idx=%0d data=%h", a, d);
                if (a != 5'd0) m_regs[a] = d;
            end
            if (cs) begin
                $display("clear start");
                m_clearing = 1'b1;
                m_clr_idx  = 1;
            end
        end
    endtask

    task automatic sweep();
        for (int i = 0; i < 32; i++) tick(1'b0, 5'd0, 32'h0, 1'b0, 5'(i), 5'(31 - i));
    endtask

    task automatic fill_own_index();
        for (int i = 1; i < 32; i++) tick(1'b1, 5'(i), 32'(i), 1'b0, 5'(i), 5'd0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        reset_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        clr_start = 1'b0; rd_addr_a = '0; rd_addr_b = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Reset state on every index, both ports.
        sweep();

        // Directed writes to 7 and 31.
        tick(1'b1, 5'd7,  32'hDEADBEEF, 1'b0, 5'd7, 5'd31);
        tick(1'b1, 5'd31, 32'h12345678, 1'b0, 5'd7, 5'd31);
        tick(1'b0, 5'd0,  32'h0,        1'b0, 5'd7, 5'd31);
        check("rd7",  rd_data_a, 32'hDEADBEEF);
        check("rd31", rd_data_b, 32'h12345678);
        sweep();

        // Write to index 0 is accepted and discarded.
        tick(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0);
        tick(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0);
        check("rd0", rd_data_a, 32'h0);

        // Same-cycle write/read of index 5 (forwarding depends on build).
        tick(1'b1, 5'd5, 32'h1,        1'b0, 5'd5, 5'd5);
        tick(1'b1, 5'd5, 32'hA5A5A5A5, 1'b0, 5'd5, 5'd7);
        tick(1'b0, 5'd0, 32'h0,        1'b0, 5'd5, 5'd5);
        check("rd5_after", rd_data_a, 32'hA5A5A5A5);

        // Random traffic including occasional clears.
        for (int k = 0; k < 300; k++) begin
            tick(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
                 1'($urandom_range(0, 49) == 0),
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end
        n = 0;
        while (clr_busy && n < 40) begin
            tick(1'b0, 5'd0, 32'h0, 1'b0, 5'd1, 5'd2);
            n++;
        end

        // Full clear sequence: length, mid-sequence contents, final contents.
        fill_own_index();
        tick(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd20);
        n = 0;
        while (clr_busy && n < 40) begin
            if (n == 10) begin
                check("mid_rd5",  rd_data_a, 32'd0);
                check("mid_rd20", rd_data_b, 32'd20);
            end
            tick(1'b1, 5'd9, 32'hBAD0BAD0, 1'b1, 5'd5, 5'd20);
            n++;
        end
        check("clr_len", 32'(n), 32'd31);
        sweep();

        // Reset during the eighth clear cycle aborts the sequence.
        fill_own_index();
        tick(1'b0, 5'd0, 32'h0, 1'b1, 5'd30, 5'd31);
        for (int k = 0; k < 7; k++) tick(1'b0, 5'd0, 32'h0, 1'b0, 5'd30, 5'd31);
        reset_n = 1'b0;
        tick(1'b0, 5'd0, 32'h0, 1'b0, 5'd30, 5'd31);
        reset_n = 1'b1;
        check("abort_busy", {31'b0, clr_busy}, 32'd0);
        tick(1'b1, 5'd3, 32'h00000033, 1'b0, 5'd3, 5'd30);
        tick(1'b0, 5'd0, 32'h0,        1'b0, 5'd3, 5'd30);
        check("rd3_after_abort", rd_data_a, 32'h00000033);
        sweep();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
